// File: rtl/ats_cmd_frontend_if.sv
// Command front-end bus: client request/beat side plus assembled-instruction output side.
// The slave modport is the front-end itself; master is whatever drives clients and consumes output.
interface ats_cmd_frontend_if #(
    parameter int NCLIENT = 2,
    parameter int CW      = 16,
    parameter int BEATS   = 2
);
    localparam int IW = CW * BEATS;
    localparam int XW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

    logic                  req;
    logic [NCLIENT*CW-1:0] ctrl;
    logic                  ready;
    logic [1:0]            stat;
    logic                  out_valid;
    logic                  out_ready;
    logic [IW-1:0]         out_instr;
    logic [XW-1:0]         out_client;

    modport master (
        output req, ctrl, out_ready,
        input  ready, stat, out_valid, out_instr, out_client
    );

    modport slave (
        input  req, ctrl, out_ready,
        output ready, stat, out_valid, out_instr, out_client
    );
endinterface

// File: rtl/ats_cmd_frontend.sv
// Multi-client instruction capture, per-client FIFOs and output arbitration.
// Define ATS_CMD_STRICT_PRIO_EN for fixed priority (lowest client wins) instead of round-robin.
module ats_cmd_frontend #(
    parameter int NCLIENT = 2,
    parameter int CW      = 16,
    parameter int BEATS   = 2,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    ats_cmd_frontend_if.slave  bus
);
    localparam int IW = CW * BEATS;
    localparam int XW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

    state_t              state;
    logic [BW-1:0]       beat;
    logic                sticky_ovr;
    logic                sticky_ill;
    logic [IW-1:0]       instr_p0 [NCLIENT];
    logic [IW-1:0]       mem_p1   [NCLIENT][DEPTH];
    logic [AW:0]         wr_ptr   [NCLIENT];
    logic [AW:0]         rd_ptr   [NCLIENT];
    logic [NCLIENT-1:0]  empty;
    logic [NCLIENT-1:0]  full;
    logic [NCLIENT-1:0]  push;
    logic [NCLIENT-1:0]  pop;
    logic [NCLIENT-1:0]  illegal;
    logic [XW-1:0]       grant;
    logic [XW-1:0]       sel;
    logic [XW-1:0]       hold_client;
    logic                hold;
    logic                found;
    logic                ready_w;
    logic                vld_p1;

    always_comb begin
        empty   = '0;
        full    = '0;
        push    = '0;
        illegal = '0;
        pop     = '0;
        for (int i = 0; i < NCLIENT; i++) begin
            empty[i]   = (wr_ptr[i] == rd_ptr[i]);
            full[i]    = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                         (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
            illegal[i] = (state == COMMIT) && (instr_p0[i][IW-1 -: 3] == 3'b100);
            push[i]    = (state == COMMIT) && (instr_p0[i][IW-1 -: 3] != 3'b000) &&
                         (instr_p0[i][IW-1 -: 3] != 3'b100) && !full[i];
            pop[i]     = vld_p1 && bus.out_ready && (sel == XW'(i));
        end
    end

    assign ready_w = (state == IDLE) && !(|full);
    assign vld_p1  = !(&empty);
    // A stalled output keeps its grant so a late push cannot change what is presented.
    assign sel     = hold ? hold_client : grant;

`ifdef ATS_CMD_STRICT_PRIO_EN
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NCLIENT; k++) begin
            if (!found && !empty[k]) begin
                grant = XW'(k);
                found = 1'b1;
            end
        end
    end
`else
    logic [XW-1:0] rr_ptr;

    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < NCLIENT; k++) begin
            if (!found && !empty[(int'(rr_ptr) + k) % NCLIENT]) begin
                grant = XW'((int'(rr_ptr) + k) % NCLIENT);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (|pop) begin
            rr_ptr <= (sel == XW'(NCLIENT - 1)) ? '0 : sel + XW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            beat        <= '0;
            sticky_ovr  <= 1'b0;
            sticky_ill  <= 1'b0;
            hold        <= 1'b0;
            hold_client <= '0;
            for (int i = 0; i < NCLIENT; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            if (bus.req && !ready_w)
                sticky_ovr <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.req && ready_w) begin
                        state      <= CAPTURE;
                        beat       <= '0;
                        sticky_ovr <= 1'b0;
                        sticky_ill <= 1'b0;
                    end
                end
                CAPTURE: begin
                    beat <= beat + BW'(1);
                    if (beat == BW'(BEATS - 1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    if (|illegal)
                        sticky_ill <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            for (int i = 0; i < NCLIENT; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + (AW+1)'(1);
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + (AW+1)'(1);
            end
            hold        <= vld_p1 && !bus.out_ready;
            hold_client <= sel;
        end
    end

    // Stage p0: beats shift in from the LSB end, so the first beat lands in the MSBs.
    // Stage p1: committed instructions are written into the per-client FIFO storage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCLIENT; i++) begin
            if (state == CAPTURE)
                instr_p0[i] <= (instr_p0[i] << CW) | IW'(bus.ctrl[i*CW +: CW]);
            if (push[i])
                mem_p1[i][wr_ptr[i][AW-1:0]] <= instr_p0[i];
        end
    end

    assign bus.ready      = ready_w;
    assign bus.stat       = (state != IDLE) ? 2'b01 :
                            sticky_ovr      ? 2'b11 :
                            sticky_ill      ? 2'b10 : 2'b00;
    assign bus.out_valid  = vld_p1;
    assign bus.out_instr  = vld_p1 ? mem_p1[sel][rd_ptr[sel][AW-1:0]] : '0;
    assign bus.out_client = vld_p1 ? sel : '0;
endmodule

// File: doc/ats_cmd_frontend.md
ATS_CMD_FRONTEND -- requirements
Module: ats_cmd_frontend

Interface
REQ-001 Parameter NCLIENT, default 2, number of client control ports.
REQ-002 Parameter CW, default 16, bits per control beat.
REQ-003 Parameter BEATS, default 2, beats per instruction; instruction width IW = CW*BEATS.
REQ-004 Parameter DEPTH, default 4, per-client instruction FIFO entries (power of 2, >=2).
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 req  input  1  start of instruction transfer, sampled when ready=1.
REQ-009 ctrl  input  NCLIENT*CW  client i beat at ctrl[i*CW +: CW].
REQ-010 ready  output  1  block accepts req this cycle.
REQ-011 stat  output  2  status: 00 OK, 01 BUSY, 10 ILLEGAL, 11 OVERRUN.
REQ-012 out_valid  output  1  out_instr/out_client valid.
REQ-013 out_ready  input  1  downstream core accepts instruction.
REQ-014 out_instr  output  IW  assembled instruction, first beat in MSBs.
REQ-015 out_client  output  max(1,clog2(NCLIENT))  source client index.

Function
REQ-016 FSM states IDLE, CAPTURE, COMMIT SHALL be implemented.
REQ-017 ready SHALL be 1 only in IDLE with every client FIFO holding at least one free entry.
REQ-018 req=1 with ready=1 in IDLE SHALL move to CAPTURE, clear the beat counter, clear sticky stat flags.
REQ-019 req=1 with ready=0 SHALL be ignored and set sticky OVERRUN.
REQ-020 CAPTURE SHALL latch each client's ctrl slice on each of the BEATS cycles following the accepted req cycle, first beat into bits [IW-1 -: CW].
REQ-021 After beat BEATS-1 the FSM SHALL enter COMMIT for exactly one cycle, then IDLE.
REQ-022 In COMMIT, per client: opcode out_instr[IW-1:IW-3]=000 (Nop) SHALL be discarded silently; opcode 100 SHALL be discarded and set sticky ILLEGAL; all other opcodes SHALL be pushed into that client's FIFO.
REQ-023 Latency: req accepted at cycle T, push at T+BEATS+1, earliest out_valid at T+BEATS+2.
REQ-024 out_valid SHALL be 1 whenever any FIFO is non-empty; out_instr/out_client SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Pop occurs on out_valid&out_ready; a push and pop on the same FIFO in one cycle SHALL both take effect.
REQ-026 Arbitration (default build) SHALL be round-robin: after a pop from client k, client k+1 (mod NCLIENT) has highest priority.
REQ-027 stat priority: BUSY when not IDLE; else OVERRUN if sticky set; else ILLEGAL if sticky set; else OK.
REQ-028 FIFO pointers SHALL wrap at DEPTH; full/empty distinguished by an extra pointer bit.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, empty all FIFOs, clear sticky flags, arbiter pointer=0.
REQ-030 Reset values: ready=1 after release, stat=00, out_valid=0, out_instr=0, out_client=0.
REQ-031 reset asserted mid-CAPTURE SHALL abandon the partial instruction; nothing is pushed.

Configuration
REQ-032 Macro ATS_CMD_STRICT_PRIO_EN defined: arbitration SHALL be fixed priority, lowest client index wins.
REQ-033 Macro ATS_CMD_STRICT_PRIO_EN undefined: round-robin per REQ-026.

Verification (NCLIENT=2, CW=16, BEATS=2, DEPTH=4)
REQ-034 Reset held 4 cycles, released -> ready=1, stat=00, out_valid=0.
REQ-035 req, then A beats 0x2000,0x0000 and B beats 0x2240,0x0000, out_ready=1 -> out_valid at T+4 with 0x20000000/client 0, next cycle 0x22400000/client 1.
REQ-036 A beats 0xA305,0x0064, B beats 0x0000,0x0000 -> single output 0xA3050064/client 0; B Nop dropped; stat=00.
REQ-037 A beats 0x8000,0x1234 -> nothing output for A, stat=10 until next accepted req.
REQ-038 out_ready=0, 4 transfers of valid instructions -> ready=0; 5th req -> ignored, stat=11; out_ready=1 -> 8 instructions drain alternating client 0,1 (client 0,0,0,0,1,1,1,1 with ATS_CMD_STRICT_PRIO_EN).
REQ-039 reset=0 asserted during second beat -> FIFOs empty, out_valid=0, next transfer captured correctly.
